// File: rtl/pwm_multichannel_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_multichannel_gen : N-channel PWM with debounced per-channel duty steps
// Revision 1.0
// ---------------------------------------------------------------------------

module pwm_btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [DW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 != level) begin
        // The edge that completes DEB_CYCLES mismatching cycles flips the level.
        if (stable_cnt == DEB_LAST) begin
          level      <= sync2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + DW'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  assign press = level & ~level_d;
endmodule

module pwm_multichannel_gen #(
  parameter int N_CH       = 3,
  parameter int CNT_W      = 16,
  parameter int PERIOD     = 1000,
  parameter int STEP       = 100,
  parameter int DUTY_MIN   = 0,
  parameter int DUTY_MAX   = 1000,
  parameter int DUTY_INIT  = 0,
  parameter int DEB_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [N_CH-1:0]       i_inc,
  input  logic [N_CH-1:0]       i_dec,
  output logic [N_CH-1:0]       o_pwm,
  output logic [N_CH*CNT_W-1:0] o_duty,
  output logic                  o_period_start,
  output logic [N_CH-1:0]       o_sat_hi,
  output logic [N_CH-1:0]       o_sat_lo
);
  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DMIN        = CNT_W'(DUTY_MIN);
  localparam logic [CNT_W-1:0] DMAX        = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] DINIT       = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W-1:0] STEP_C      = CNT_W'(STEP);
  localparam logic [CNT_W:0]   STEP_X      = CW1'(STEP);
  localparam logic [CNT_W:0]   MAX_X       = CW1'(DUTY_MAX);
  localparam logic [CNT_W:0]   FLOOR_X     = CW1'(DUTY_MIN + STEP);

  logic [CNT_W-1:0] cnt;
  logic             period_start_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt            <= '0;
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= i_enable && (cnt == '0);
      if (!i_enable || cnt == PERIOD_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign o_period_start = period_start_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic             inc_press;
    logic             dec_press;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] shadow_next;
    logic [CNT_W-1:0] active;
    logic [CNT_W:0]   up_sum;
    logic             pwm_q;

    pwm_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
      .clk   (i_clk),
      .rst   (i_reset),
      .din   (i_inc[c]),
      .press (inc_press)
    );

    pwm_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
      .clk   (i_clk),
      .rst   (i_reset),
      .din   (i_dec[c]),
      .press (dec_press)
    );

    // One extra bit of headroom so the clamp decisions never see a wrapped value.
    always_comb begin
      up_sum      = {1'b0, shadow} + STEP_X;
      shadow_next = shadow;
      if (inc_press && !dec_press) begin
        shadow_next = (up_sum > MAX_X) ? DMAX : up_sum[CNT_W-1:0];
      end else if (dec_press && !inc_press) begin
        shadow_next = ({1'b0, shadow} < FLOOR_X) ? DMIN : shadow - STEP_C;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        shadow <= DINIT;
        active <= DINIT;
        pwm_q  <= 1'b0;
      end else begin
        shadow <= shadow_next;
        // Active duty only changes at the wrap so a period is never cut short.
        if (!i_enable || cnt == PERIOD_LAST) begin
          active <= shadow;
        end
        pwm_q <= i_enable && (cnt < active);
      end
    end

    assign o_pwm[c]                    = pwm_q;
    assign o_duty[c*CNT_W +: CNT_W]    = shadow;
    assign o_sat_hi[c]                 = (shadow == DMAX);
    assign o_sat_lo[c]                 = (shadow == DMIN);
  end
endmodule

`default_nettype wire

// File: tb/tb_pwm_multichannel_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pwm_multichannel_gen : directed stimulus, per-cycle reference model check
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pwm_multichannel_gen;
  localparam int N    = 3;
  localparam int W    = 16;
  localparam int P    = 1000;
  localparam int STEP = 100;
  localparam int DMIN = 0;
  localparam int DMAX = 1000;
  localparam int DINI = 0;
  localparam int DEB  = 4;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic           i_enable;
  logic [N-1:0]   i_inc;
  logic [N-1:0]   i_dec;
  logic [N-1:0]   o_pwm;
  logic [N*W-1:0] o_duty;
  logic           o_period_start;
  logic [N-1:0]   o_sat_hi;
  logic [N-1:0]   o_sat_lo;

  pwm_multichannel_gen #(
    .N_CH(N), .CNT_W(W), .PERIOD(P), .STEP(STEP), .DUTY_MIN(DMIN),
    .DUTY_MAX(DMAX), .DUTY_INIT(DINI), .DEB_CYCLES(DEB)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_inc          (i_inc),
    .i_dec          (i_dec),
    .o_pwm          (o_pwm),
    .o_duty         (o_duty),
    .o_period_start (o_period_start),
    .o_sat_hi       (o_sat_hi),
    .o_sat_lo       (o_sat_lo)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase within the period, duty values as integers, and a
  // raw-sample history per button from which the debounced level is judged.
  int         m_phase;
  int         m_sh  [N];
  int         m_act [N];
  bit [N-1:0] m_pwm;
  bit         m_ps;
  bit [31:0]  hist_i [N];
  bit [31:0]  hist_d [N];
  bit         deb_i  [N];
  bit         deb_d  [N];
  bit         pend_i [N];
  bit         pend_d [N];

  // Samples taken 2..DEB+1 edges ago are the synchronised levels the debouncer
  // has seen; all DEB of them opposite to the current level means a flip now.
  function automatic bit flips(input bit [31:0] h, input bit lvl);
    bit [31:0] mask;
    bit [31:0] win;
    mask = (32'd1 << DEB) - 32'd1;
    win  = (h >> 1) & mask;
    return lvl ? (win == 32'd0) : (win == mask);
  endfunction

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_phase = 0;
      m_pwm   = '0;
      m_ps    = 1'b0;
      for (int c = 0; c < N; c++) begin
        m_sh[c] = DINI;  m_act[c] = DINI;
        hist_i[c] = '0;  hist_d[c] = '0;
        deb_i[c] = 1'b0; deb_d[c] = 1'b0;
        pend_i[c] = 1'b0; pend_d[c] = 1'b0;
      end
    end else begin
      m_ps = i_enable && (m_phase == 0);
      for (int c = 0; c < N; c++) begin
        m_pwm[c] = i_enable && (m_phase < m_act[c]);
        if (!i_enable || m_phase == P - 1) m_act[c] = m_sh[c];
        if (pend_i[c] && !pend_d[c])      m_sh[c] = (m_sh[c] + STEP > DMAX) ? DMAX : m_sh[c] + STEP;
        else if (pend_d[c] && !pend_i[c]) m_sh[c] = (m_sh[c] - STEP < DMIN) ? DMIN : m_sh[c] - STEP;
        pend_i[c] = !deb_i[c] && flips(hist_i[c], 1'b0);
        pend_d[c] = !deb_d[c] && flips(hist_d[c], 1'b0);
        if (flips(hist_i[c], deb_i[c])) deb_i[c] = !deb_i[c];
        if (flips(hist_d[c], deb_d[c])) deb_d[c] = !deb_d[c];
        hist_i[c] = {hist_i[c][30:0], i_inc[c]};
        hist_d[c] = {hist_d[c][30:0], i_dec[c]};
      end
      m_phase = i_enable ? (m_phase + 1) % P : 0;
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      bit [N-1:0] e_hi;
      bit [N-1:0] e_lo;
      chk("pwm", o_pwm, m_pwm);
      chk("period_start", o_period_start, m_ps);
      for (int c = 0; c < N; c++) begin
        chk($sformatf("duty%0d", c), o_duty[c*W +: W], m_sh[c]);
        e_hi[c] = (m_sh[c] == DMAX);
        e_lo[c] = (m_sh[c] == DMIN);
      end
      chk("sat_hi", o_sat_hi, e_hi);
      chk("sat_lo", o_sat_lo, e_lo);
    end
  end

  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_period_start && n < 2500);
    if (!o_period_start) chk("period_start_timeout", 0, 1);
  endtask

  // Called on a period-start sample; returns high cycles over one period.
  task automatic count_high(input int ch, output int highs);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      highs += o_pwm[ch];
      @(negedge i_clk);
    end
  endtask

  task automatic press(input int ch, input bit up, input int len);
    if (up) i_inc[ch] = 1'b1; else i_dec[ch] = 1'b1;
    repeat (len) @(negedge i_clk);
    i_inc[ch] = 1'b0;
    i_dec[ch] = 1'b0;
    repeat (10) @(negedge i_clk);
  endtask

  initial begin
    int n;
    int h1;
    int h2;
    i_reset = 1'b1; i_enable = 1'b1; i_inc = '0; i_dec = '0;
    repeat (2) @(negedge i_clk);
    chk_on = 1'b1;
    chk("rst_duty", o_duty, 0);
    chk("rst_pwm", o_pwm, 0);
    chk("rst_sat_lo", o_sat_lo, 3'b111);
    chk("rst_sat_hi", o_sat_hi, 3'b000);
    i_reset = 1'b0;

    // Idle: period start spacing.
    wait_ps();
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_period_start && n < 2500);
    chk("ps_gap", n, P);

    // Held inc on ch0: step lands exactly DEB+3 edges after first sample.
    i_inc[0] = 1'b1;
    repeat (6) @(negedge i_clk);
    chk("lat_before", o_duty[0 +: W], 0);
    @(negedge i_clk);
    chk("lat_after", o_duty[0 +: W], 100);
    repeat (13) @(negedge i_clk);
    i_inc[0] = 1'b0;
    wait_ps(); wait_ps();
    count_high(0, h1);
    chk("ch0_high_100", h1, 100);
    chk("ch1_untouched", o_duty[W +: W], 0);

    // Short pulse rejected; long hold gives one step.
    press(1, 1'b1, 3);
    repeat (10) @(negedge i_clk);
    chk("short_pulse", o_duty[W +: W], 0);
    press(1, 1'b1, 5000);
    chk("long_hold", o_duty[W +: W], 100);

    // Saturation high then low on ch2.
    for (int k = 0; k < 11; k++) press(2, 1'b1, 6);
    chk("sat_hi_duty", o_duty[2*W +: W], 1000);
    chk("sat_hi_flag", o_sat_hi[2], 1'b1);
    wait_ps(); wait_ps();
    count_high(2, h1);
    chk("ch2_const_high", h1, P);
    for (int k = 0; k < 11; k++) press(2, 1'b0, 6);
    chk("sat_lo_duty", o_duty[2*W +: W], 0);
    chk("sat_lo_flag", o_sat_lo[2], 1'b1);
    wait_ps(); wait_ps();
    count_high(2, h1);
    chk("ch2_const_low", h1, 0);

    // Mid-period step on ch0 (500 -> 600) at counter 300.
    for (int k = 0; k < 4; k++) press(0, 1'b1, 6);
    wait_ps(); wait_ps();
    h1 = 0; h2 = 0;
    for (int i = 0; i < 2 * P; i++) begin
      if (i == 299) i_inc[0] = 1'b1;
      if (i == 309) i_inc[0] = 1'b0;
      if (i == 306) chk("mid_duty_now", o_duty[0 +: W], 600);
      if (i < P) h1 += o_pwm[0]; else h2 += o_pwm[0];
      @(negedge i_clk);
    end
    chk("mid_cur_period", h1, 500);
    chk("mid_next_period", h2, 600);

    // Simultaneous inc and dec cancel.
    i_inc[1] = 1'b1; i_dec[1] = 1'b1;
    repeat (10) @(negedge i_clk);
    i_inc[1] = 1'b0; i_dec[1] = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("inc_dec_cancel", o_duty[W +: W], 100);

    // Reset at counter 700.
    wait_ps();
    repeat (699) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("midrst_pwm", o_pwm, 0);
    chk("midrst_duty", o_duty, 0);
    chk("midrst_sat_lo", o_sat_lo, 3'b111);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("midrst_restart", o_period_start, 1'b1);

    // Enable low then high again, with a nonzero duty on ch0.
    press(0, 1'b1, 6);
    repeat (20) @(negedge i_clk);
    i_enable = 1'b0;
    repeat (30) @(negedge i_clk);
    chk("disabled_pwm", o_pwm, 0);
    i_enable = 1'b1;
    repeat (1100) @(negedge i_clk);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
